rocketcpu_dma: RTL and testbench

Word-granular memory-to-memory copy engine for the RocketCPU SoC. It has two Wishbone ports. A responder port lets the SERV core program the source, destination and length registers and start a transfer. An initiator port then issues alternating read/write cycles into the shared memory map, for example flash or RAM into RAM or the audio registers, until the programmed word count is exhausted. It raises a one-cycle completion interrupt when done.

---
 rtl/rocketcpu_dma.sv | 171 +++++++++++++++++
 tb/tb_rocketcpu_dma.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_dma.sv
// rocketcpu_dma: word-granular memory-to-memory copy engine.
// Wishbone config responder plus alternating read/write initiator.
module rocketcpu_dma #(
  parameter int LEN_W = 16
) (
  input  logic        i_wb_clk,
  input  logic        reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_dma_adr,
  output logic [31:0] o_dma_dat,
  output logic [3:0]  o_dma_sel,
  output logic        o_dma_we,
  output logic        o_dma_cyc,
  input  logic [31:0] i_dma_rdt,
  input  logic        i_dma_ack,
  output logic        o_irq
);

  typedef enum logic [2:0] {
    IDLE, RD, RGAP, WR, WGAP
  } state_t;

  state_t           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [31:0]      adr_q;
  logic [31:0]      rdt_q;
  logic [LEN_W-1:0] len_q;
  logic             busy_q;
  logic             done_q;
  logic             ack_q;
  logic             cyc_q;
  logic             we_q;
  logic             irq_q;

  logic [1:0]  sel;
  logic        cfg_acc;
  logic        cfg_wr;
  logic        start;
  logic        clr;
  logic [31:0] rdata;
  logic        unused_adr;

  assign sel     = i_wb_adr[3:2];
  assign cfg_acc = i_wb_cyc & ~ack_q;
  assign cfg_wr  = cfg_acc & i_wb_we;
  assign start   = cfg_wr & (sel == 2'd3) & i_wb_dat[0];
  assign clr     = cfg_wr & (sel == 2'd3) & i_wb_dat[1];

  assign unused_adr = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

  always_comb begin
    rdata = '0;
    unique case (sel)
      2'd0: rdata = src_q;
      2'd1: rdata = dst_q;
      2'd2: rdata = 32'(len_q);
      2'd3: rdata = {30'b0, done_q, busy_q};
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
    end else begin
      ack_q <= cfg_acc;
      if (cfg_acc) rdt_q <= rdata;
    end
  end

  always_ff @(posedge i_wb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      adr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_wr) begin
            unique case (sel)
              2'd0: src_q <= {i_wb_dat[31:2], 2'b00};
              2'd1: dst_q <= {i_wb_dat[31:2], 2'b00};
              2'd2: len_q <= i_wb_dat[LEN_W-1:0];
              2'd3: ;
            endcase
          end
          if (start) begin
            if (len_q != '0) begin
              state_q <= RD;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              done_q <= 1'b1;
              irq_q  <= 1'b1;
            end
          end else if (clr) begin
            done_q <= 1'b0;
          end
        end
        RD: begin
          // first RD after a start spends one cycle launching the bus cycle
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= src_q;
          end else if (i_dma_ack) begin
            data_q  <= i_dma_rdt;
            cyc_q   <= 1'b0;
            state_q <= RGAP;
          end
        end
        RGAP: begin
          cyc_q   <= 1'b1;
          we_q    <= 1'b1;
          adr_q   <= dst_q;
          state_q <= WR;
        end
        WR: begin
          if (i_dma_ack) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            src_q   <= src_q + 32'd4;
            dst_q   <= dst_q + 32'd4;
            len_q   <= len_q - LEN_W'(1);
            state_q <= WGAP;
          end
        end
        WGAP: begin
          if (len_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= src_q;
            state_q <= RD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_rdt  = rdt_q;
  assign o_dma_adr = adr_q;
  assign o_dma_dat = data_q;
  assign o_dma_sel = 4'hF;
  assign o_dma_we  = we_q;
  assign o_dma_cyc = cyc_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_rocketcpu_dma.sv
// tb_rocketcpu_dma: register table, copies via a RAM responder model,
// zero length, busy protection, wait states and mid-transfer reset.
module tb_rocketcpu_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [31:0] dma_adr;
  logic [31:0] dma_dat;
  logic [3:0]  dma_sel;
  logic        dma_we;
  logic        dma_cyc;
  logic [31:0] dma_rdt;
  logic        dma_ack;
  logic        irq;

  always #5 clk = ~clk;

  rocketcpu_dma #(.LEN_W(16)) dut (
    .i_wb_clk (clk),
    .reset_n  (rst_n),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .o_dma_adr(dma_adr),
    .o_dma_dat(dma_dat),
    .o_dma_sel(dma_sel),
    .o_dma_we (dma_we),
    .o_dma_cyc(dma_cyc),
    .i_dma_rdt(dma_rdt),
    .i_dma_ack(dma_ack),
    .o_irq    (irq)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic [31:0] mem [logic [31:0]];
  wr_t         sb[$];
  int          wait_n = 0;
  int          rcnt;
  logic [31:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;

  // RAM responder with wait_n wait states; writes are checked against sb
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_ack <= 1'b0;
      dma_rdt <= '0;
      rcnt    <= 0;
    end else if (dma_ack) begin
      dma_ack <= 1'b0;
    end else if (dma_cyc) begin : resp
      wr_t e;
      if (rcnt == 0) begin
        cap_adr <= dma_adr;
        cap_dat <= dma_dat;
        cap_we  <= dma_we;
      end else begin
        check("stable_adr", {32'b0, dma_adr}, {32'b0, cap_adr});
        check("stable_we", {63'b0, dma_we}, {63'b0, cap_we});
        if (dma_we) check("stable_dat", {32'b0, dma_dat}, {32'b0, cap_dat});
      end
      if (rcnt == wait_n) begin
        dma_ack <= 1'b1;
        rcnt    <= 0;
        if (dma_we) begin
          mem[dma_adr] = dma_dat;
          if (sb.size() == 0) begin
            check("sb_unexpected_write", {32'b0, dma_adr}, 64'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("wr_adr", {32'b0, dma_adr}, {32'b0, e.adr});
            check("wr_dat", {32'b0, dma_dat}, {32'b0, e.dat});
          end
        end else begin
          dma_rdt <= mem.exists(dma_adr) ? mem[dma_adr] : 32'hBAD0_BAD0;
        end
      end else begin
        rcnt <= rcnt + 1;
      end
    end
  end

  int irq_cnt = 0;
  int cyc_cnt = 0;
  int cyc_no = 0;
  logic ack_irq;

  always @(negedge clk) begin
    if (irq) irq_cnt++;
    if (dma_cyc) cyc_cnt++;
  end
  always @(posedge clk) cyc_no++;

  task automatic cfg(input logic [1:0] s, input logic [31:0] d,
                     input logic w, output logic [31:0] r, output int lat);
    @(negedge clk);
    wb_adr = {28'b0, s, 2'b00};
    wb_dat = d;
    wb_we  = w;
    wb_cyc = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wb_ack && lat < 8);
    r       = wb_rdt;
    ack_irq = irq;
    wb_cyc  = 1'b0;
    wb_we   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    cfg(s, d, 1'b1, r, lat);
    check("wr_ack_latency", 64'(lat), 64'd1);
  endtask

  task automatic rd(input string nm, input logic [1:0] s,
                    input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    cfg(s, 32'h0, 1'b0, r, lat);
    check(nm, {32'b0, r}, {32'b0, exp});
  endtask

  task automatic wait_irq(input int budget, output int at);
    int n = 0;
    while (!irq && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!irq) check("irq_timeout", 64'd0, 64'd1);
    at = cyc_no;
  endtask

  task automatic load(input logic [31:0] src, input logic [31:0] dst,
                      input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = (base != 0) ? base + 32'(i) : $urandom;
      mem[src + 32'(4 * i)] = v;
      sb.push_back('{adr: dst + 32'(4 * i), dat: v});
    end
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int waits,
                          input logic [31:0] base);
    int irq0;
    int t0;
    int t1;
    wait_n = waits;
    load(src, dst, n, base);
    wr(2'd0, src);
    wr(2'd1, dst);
    wr(2'd2, 32'(n));
    irq0 = irq_cnt;
    wr(2'd3, 32'h1);
    check("start_cyc_in_ack", {63'b0, dma_cyc}, 64'd0);
    @(negedge clk);
    check("start_cyc_next", {63'b0, dma_cyc}, 64'd1);
    t0 = cyc_no;
    wait_irq(200, t1);
    check("copy_cycles", 64'(t1 - t0), 64'(n * (6 + 2 * waits)));
    repeat (3) @(negedge clk);
    check("copy_irq_pulses", 64'(irq_cnt - irq0), 64'd1);
    check("copy_sb_drained", 64'(sb.size()), 64'd0);
    rd("copy_status", 2'd3, 32'h2);
    rd("copy_len", 2'd2, 32'h0);
    rd("copy_src_end", 2'd0, src + 32'(4 * n));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int irq0;
    int cyc0;
    int n;
    int t1;

    vecs[0] = '{1'b1, 2'd0, 32'h0000_1003, 32'h0};
    vecs[1] = '{1'b1, 2'd1, 32'h0000_2000, 32'h0};
    vecs[2] = '{1'b1, 2'd2, 32'h0000_0005, 32'h0};
    vecs[3] = '{1'b0, 2'd0, 32'h0,         32'h0000_1000};
    vecs[4] = '{1'b0, 2'd1, 32'h0,         32'h0000_2000};
    vecs[5] = '{1'b0, 2'd2, 32'h0,         32'h0000_0005};
    vecs[6] = '{1'b0, 2'd3, 32'h0,         32'h0000_0000};
    vecs[7] = '{1'b1, 2'd2, 32'hFFFF_2345, 32'h0};
    vecs[8] = '{1'b0, 2'd2, 32'h0,         32'h0000_2345};
    vecs[9] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {wb_ack, wb_rdt, dma_cyc, dma_we, dma_sel, irq, 2'b0, dma_adr[19:0]},
          {1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 1'b0, 2'b0, 20'h0});
    check("reset_adr_dat", {dma_adr, dma_dat}, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      logic [31:0] r;
      int lat;
      cfg(vecs[i].sel, vecs[i].dat, vecs[i].we, r, lat);
      check($sformatf("reg_ack_lat_%0d", i), 64'(lat), 64'd1);
      if (!vecs[i].we)
        check($sformatf("reg_rd_%0d", i), {32'b0, r}, {32'b0, vecs[i].exp});
      @(negedge clk);
      check($sformatf("reg_ack_one_%0d", i), {63'b0, wb_ack}, 64'd0);
    end
    rd("reg_src_mask", 2'd0, 32'hFFFF_FFFC);

    run_copy(32'h100, 32'h200, 4, 0, 32'hA0);
    check("basic_mem_20c", {32'b0, mem[32'h20C]}, 64'hA3);

    wr(2'd3, 32'h2);
    rd("clear_done", 2'd3, 32'h0);
    wr(2'd2, 32'h0);
    irq0 = irq_cnt;
    cyc0 = cyc_cnt;
    wr(2'd3, 32'h1);
    check("zl_irq_at_ack", {63'b0, ack_irq}, 64'd1);
    repeat (10) @(negedge clk);
    check("zl_no_cyc", 64'(cyc_cnt - cyc0), 64'd0);
    check("zl_irq_pulses", 64'(irq_cnt - irq0), 64'd1);
    rd("zl_status", 2'd3, 32'h2);

    wait_n = 0;
    load(32'h1000, 32'h3000, 3, 0);
    wr(2'd0, 32'h1000);
    wr(2'd1, 32'h3000);
    wr(2'd2, 32'h3);
    irq0 = irq_cnt;
    wr(2'd3, 32'h1);
    rd("busy_status", 2'd3, 32'h1);
    wr(2'd0, 32'hDEAD_0000);
    wr(2'd3, 32'h1);
    wait_irq(200, t1);
    repeat (10) @(negedge clk);
    check("busy_irq_pulses", 64'(irq_cnt - irq0), 64'd1);
    check("busy_sb_drained", 64'(sb.size()), 64'd0);
    rd("busy_src_end", 2'd0, 32'h100C);
    rd("busy_dst_end", 2'd1, 32'h300C);

    run_copy(32'h800, 32'h900, 2, 3, 0);

    wait_n = 0;
    load(32'h300, 32'h400, 3, 0);
    wr(2'd0, 32'h300);
    wr(2'd1, 32'h400);
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h1);
    n = 0;
    while (!(dma_cyc && dma_we && dma_adr == 32'h404) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wr2", {63'b0, dma_cyc & dma_we}, 64'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_cyc_drop", {63'b0, dma_cyc}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_src", 2'd0, 32'h0);
    rd("rst_dst", 2'd1, 32'h0);
    rd("rst_len", 2'd2, 32'h0);
    rd("rst_status", 2'd3, 32'h0);
    run_copy(32'h500, 32'h600, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
